// File: rtl/mqcr_fmap_buffer_pkg.sv
// Shared CNN stream definitions used by the feature-map buffer.
//   FEATURE_MAP_RESOLUTION : width of one signed feature-map sample
//   FEATURE_MAP_ADDRWIDE   : width of a row-major feature-map location
//   st_mqc_rec             : one upstream sample (valid, data, addr)
//   fmap_state_e           : buffer phase, FILL or DRAIN
package mqcr_fmap_buffer_pkg;

  localparam int FEATURE_MAP_RESOLUTION = 16;
  localparam int FEATURE_MAP_ADDRWIDE   = 9;

  typedef logic signed [FEATURE_MAP_RESOLUTION-1:0] fmap_data_t;
  typedef logic [FEATURE_MAP_ADDRWIDE-1:0]          fmap_addr_t;

  typedef struct packed {
    logic       valid;
    fmap_data_t data;
    fmap_addr_t addr;
  } st_mqc_rec;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } fmap_state_e;

  // True when a row-major location lies inside a frame of depth locations.
  function automatic logic is_valid_addr(input fmap_addr_t addr, input int depth);
    return (int'(addr) < depth);
  endfunction

endpackage

// File: rtl/mqcr_fmap_buffer_if.sv
// Bundle of the buffer's two streams plus its debug state.
//   rec_*      : upstream sample stream into the buffer
//   fmap_*     : downstream readout stream out of the buffer
//   frame_done : one-cycle pulse after the last readout sample is taken
//   err_addr   : sticky out-of-range address flag
//   state      : current FILL/DRAIN phase for observation
// Handshake: on both streams a transfer happens on a rising clock edge where
// valid and ready are both high; a source holding valid may not change its
// payload until that edge, and ready may depend on nothing but registers.
interface mqcr_fmap_buffer_if;
  import mqcr_fmap_buffer_pkg::*;

  logic        rec_valid;
  fmap_data_t  rec_data;
  fmap_addr_t  rec_addr;
  logic        rec_ready;
  logic        fmap_valid;
  fmap_data_t  fmap_data;
  fmap_addr_t  fmap_addr;
  logic        fmap_last;
  logic        fmap_ready;
  logic        frame_done;
  logic        err_addr;
  fmap_state_e state;

  // Producer/consumer side surrounding the buffer.
  modport master (
    output rec_valid, rec_data, rec_addr, fmap_ready,
    input  rec_ready, fmap_valid, fmap_data, fmap_addr, fmap_last,
    input  frame_done, err_addr, state
  );

  // The buffer itself.
  modport slave (
    input  rec_valid, rec_data, rec_addr, fmap_ready,
    output rec_ready, fmap_valid, fmap_data, fmap_addr, fmap_last,
    output frame_done, err_addr, state
  );
endinterface

// File: rtl/mqcr_fmap_buffer_fmap_ram.sv
// Simple dual-port feature-map store: one write port, one read port with a
// registered read (data appears the cycle after re_i).
//   clk_i, rst_ni    : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request
//   rdata_o          : registered read data, held while re_i is low
// A same-cycle read and write of one location returns the new data, so the
// first readout can be launched on the edge that writes the final sample.
module fmap_ram #(
  parameter int DEPTH = 377,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
    end
  end

endmodule

// File: rtl/mqcr_fmap_buffer.sv
// Feature-map frame buffer. Collects F_IN_H x F_IN_W samples arriving in any
// order (rewrites allowed), then streams the whole frame out in ascending
// row-major order and re-arms for the next frame.
//   clk_i, rst_ni                  : clock, async active-low reset
//   mqcRec_valid/data/addr_i,
//   mqcRec_ready_o                 : upstream sample stream (ready = FILL)
//   fmap_valid/data/addr/last_o,
//   fmap_ready_i                   : readout stream, last marks DEPTH-1
//   frame_done_o                   : pulse after the last readout transfer
//   err_addr_o                     : sticky, out-of-range address seen
//   dbg_state_o                    : current FILL/DRAIN phase
module mqcr_fmap_buffer
  import mqcr_fmap_buffer_pkg::*;
#(
  parameter int F_IN_H = 13,
  parameter int F_IN_W = 29
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mqcRec_valid_i,
  input  fmap_data_t  mqcRec_data_i,
  input  fmap_addr_t  mqcRec_addr_i,
  output logic        mqcRec_ready_o,
  output logic        fmap_valid_o,
  output fmap_data_t  fmap_data_o,
  output fmap_addr_t  fmap_addr_o,
  output logic        fmap_last_o,
  input  logic        fmap_ready_i,
  output logic        frame_done_o,
  output logic        err_addr_o,
  output fmap_state_e dbg_state_o
);

  localparam int DEPTH = F_IN_H * F_IN_W;
  // Counters carry one extra bit so they can hold DEPTH itself.
  localparam int PW = FEATURE_MAP_ADDRWIDE + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  fmap_state_e     state_q, state_d;
  st_mqc_rec       rec;
  logic [DEPTH-1:0] written_q;
  logic [PW-1:0]   fill_cnt_q;
  logic [PW-1:0]   rd_ptr_q;
  logic            ready_q;
  logic            valid_q;
  logic            last_q;
  logic            done_q;
  logic            err_q;
  fmap_addr_t      addr_q;
  fmap_data_t      ram_rdata;

  logic accept, in_range, ram_we, first_wr, fill_done;
  logic out_fire, frame_end, issue;

  assign rec = '{valid: mqcRec_valid_i, data: mqcRec_data_i, addr: mqcRec_addr_i};

  assign accept    = rec.valid & ready_q;
  assign in_range  = is_valid_addr(rec.addr, DEPTH);
  assign ram_we    = accept & in_range;
  assign first_wr  = ram_we & ~written_q[rec.addr];
  assign fill_done = first_wr & (fill_cnt_q == LAST_P);
  assign out_fire  = valid_q & fmap_ready_i;
  assign frame_end = out_fire & last_q;

  // Next phase and read launch. A read is launched on the edge that
  // completes the frame (address 0) and then whenever the output slot is
  // empty or being emptied, which gives one sample per cycle without
  // bubbles and freezes the RAM read register during a stall.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      FILL: begin
        if (fill_done) begin
          state_d = DRAIN;
          issue   = 1'b1;
        end
      end
      DRAIN: begin
        issue = (rd_ptr_q < DEPTH_P) & (~valid_q | fmap_ready_i);
        if (frame_end) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FILL;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q    <= 1'b0;
      written_q  <= '0;
      fill_cnt_q <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Registered so ready stays low throughout reset and rises on the
      // first edge after release; otherwise it tracks the FILL phase.
      ready_q <= (state_d == FILL);
      done_q  <= frame_end;
      if (accept & ~in_range) err_q <= 1'b1;

      if (frame_end) begin
        written_q  <= '0;
        fill_cnt_q <= '0;
      end else if (first_wr) begin
        written_q[rec.addr] <= 1'b1;
        fill_cnt_q          <= fill_cnt_q + ONE_P;
      end

      if (issue) begin
        valid_q  <= 1'b1;
        addr_q   <= rd_ptr_q[PW-2:0];
        last_q   <= (rd_ptr_q == LAST_P);
        rd_ptr_q <= rd_ptr_q + ONE_P;
      end else if (out_fire) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        if (frame_end) rd_ptr_q <= '0;
      end
    end
  end

  fmap_ram #(
    .DEPTH (DEPTH),
    .AW    (FEATURE_MAP_ADDRWIDE),
    .DW    (FEATURE_MAP_RESOLUTION)
  ) u_fmap_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (ram_we),
    .waddr_i (rec.addr),
    .wdata_i (rec.data),
    .re_i    (issue),
    .raddr_i (rd_ptr_q[PW-2:0]),
    .rdata_o (ram_rdata)
  );

  assign mqcRec_ready_o = ready_q;
  assign fmap_valid_o   = valid_q;
  assign fmap_data_o    = ram_rdata;
  assign fmap_addr_o    = addr_q;
  assign fmap_last_o    = last_q;
  assign frame_done_o   = done_q;
  assign err_addr_o     = err_q;
  assign dbg_state_o    = state_q;

endmodule
